// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex UART with integrated baud generation.
// Frame: start(0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop(1).
// Ports:
//   clk_i, rst_i               - system clock, synchronous active-high reset
//   txen_i, txstart_i, txin_i  - transmit enable, start request, data word
//   tx_o, txbusy_o, txdone_o   - serial out (idle high), busy flag, end-of-frame pulse
//   rx_i, rxen_i               - asynchronous serial in, receive enable
//   rxdata_o, rxvalid_o        - last received word, one-cycle new-word pulse
//   rxperr_o, rxferr_o         - parity / framing error for the current rxdata_o
module uart_transceiver #(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 txen_i,
  input  logic                 txstart_i,
  input  logic [DATA_BITS-1:0] txin_i,
  output logic                 tx_o,
  output logic                 txbusy_o,
  output logic                 txdone_o,
  input  logic                 rx_i,
  input  logic                 rxen_i,
  output logic [DATA_BITS-1:0] rxdata_o,
  output logic                 rxvalid_o,
  output logic                 rxperr_o,
  output logic                 rxferr_o
);

  localparam int BIT_CYC  = CLOCK_RATE / BAUD_RATE;
  localparam int OS_CYC   = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int STOP_CYC = STOP_BITS * BIT_CYC;
  localparam int TCW      = (STOP_CYC > 1) ? $clog2(STOP_CYC) : 1;
  localparam int OCW      = (OS_CYC > 1) ? $clog2(OS_CYC) : 1;
  localparam int KW       = $clog2(OVERSAMPLE);
  localparam int IW       = $clog2(DATA_BITS);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data
      $error("uart_transceiver: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_err_par
      $error("uart_transceiver: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
      $error("uart_transceiver: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_err_os
      $error("uart_transceiver: OVERSAMPLE must be even and >= 8");
    end
    if (BIT_CYC < 1 || OS_CYC < 1) begin : g_err_rate
      $error("uart_transceiver: clock too slow for BAUD_RATE/OVERSAMPLE");
    end
  endgenerate

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

  tx_state_t            r_tx_state, w_tx_state_nx;
  logic [TCW-1:0]       r_tx_cnt, w_tx_cnt_nx;
  logic [IW-1:0]        r_tx_idx, w_tx_idx_nx;
  logic [DATA_BITS-1:0] r_tx_data;
  logic                 r_tx, r_tx_busy, r_tx_done;
  logic                 w_tx_accept, w_tx_bit_nx, w_tx_par, w_tx_bit_end;

  assign w_tx_par     = (PARITY == 1) ? ~^r_tx_data : ^r_tx_data;
  assign w_tx_bit_end = (r_tx_cnt == TCW'(BIT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_tx_state <= TX_IDLE;
    else       r_tx_state <= w_tx_state_nx;
  end

  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt + 1'b1;
    w_tx_idx_nx   = r_tx_idx;
    w_tx_accept   = 1'b0;
    unique case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nx = '0;
        if (txen_i && txstart_i) begin
          w_tx_accept   = 1'b1;
          w_tx_idx_nx   = '0;
          w_tx_state_nx = TX_START;
        end
      end
      TX_START: if (w_tx_bit_end) begin
        w_tx_cnt_nx   = '0;
        w_tx_state_nx = TX_DATA;
      end
      TX_DATA: if (w_tx_bit_end) begin
        w_tx_cnt_nx = '0;
        if (r_tx_idx == IW'(DATA_BITS - 1)) begin
          w_tx_idx_nx   = '0;
          w_tx_state_nx = (PARITY != 0) ? TX_PAR : TX_STOP;
        end else begin
          w_tx_idx_nx = r_tx_idx + 1'b1;
        end
      end
      TX_PAR: if (w_tx_bit_end) begin
        w_tx_cnt_nx   = '0;
        w_tx_state_nx = TX_STOP;
      end
      TX_STOP: if (r_tx_cnt == TCW'(STOP_CYC - 1)) begin
        w_tx_cnt_nx   = '0;
        w_tx_state_nx = TX_IDLE;
      end
      default: w_tx_state_nx = TX_IDLE;
    endcase

    // Line level is derived from the next state so tx_o comes straight off a flop.
    w_tx_bit_nx = 1'b1;
    unique case (w_tx_state_nx)
      TX_START: w_tx_bit_nx = 1'b0;
      TX_DATA:  w_tx_bit_nx = r_tx_data[w_tx_idx_nx];
      TX_PAR:   w_tx_bit_nx = w_tx_par;
      default:  w_tx_bit_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_cnt  <= '0;
      r_tx_idx  <= '0;
      r_tx_data <= '0;
      r_tx      <= 1'b1;
      r_tx_busy <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_cnt  <= w_tx_cnt_nx;
      r_tx_idx  <= w_tx_idx_nx;
      r_tx      <= w_tx_bit_nx;
      r_tx_busy <= (w_tx_state_nx != TX_IDLE);
      // Done flags the final cycle of the stop period, one cycle before busy drops.
      r_tx_done <= (w_tx_state_nx == TX_STOP) && (w_tx_cnt_nx == TCW'(STOP_CYC - 1));
      if (w_tx_accept) r_tx_data <= txin_i;
    end
  end

  assign tx_o     = r_tx;
  assign txbusy_o = r_tx_busy;
  assign txdone_o = r_tx_done;

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

  rx_state_t            r_rx_state, w_rx_state_nx;
  logic                 r_rx_s1, r_rx_s2, r_rx_prev, r_rx_armed, r_rx_par;
  logic [OCW-1:0]       r_os_cnt;
  logic [KW-1:0]        r_rx_tcnt, w_rx_tcnt_nx;
  logic [IW-1:0]        r_rx_idx, w_rx_idx_nx;
  logic [DATA_BITS-1:0] r_rx_shift, r_rxdata;
  logic                 r_rxvalid, r_rxperr, r_rxferr;
  logic                 w_os_tick, w_rx_fall, w_rx_bit_mid;
  logic                 w_rx_shift_en, w_rx_par_en, w_rx_done, w_rx_perr;

  assign w_os_tick    = (r_os_cnt == OCW'(OS_CYC - 1));
  assign w_rx_fall    = r_rx_prev & ~r_rx_s2;
  assign w_rx_bit_mid = w_os_tick && (r_rx_tcnt == KW'(OVERSAMPLE - 1));
  assign w_rx_perr    = (PARITY != 0) && ((^{r_rx_shift, r_rx_par}) ^ (PARITY == 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_rx_state <= RX_IDLE;
    else       r_rx_state <= w_rx_state_nx;
  end

  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_tcnt_nx  = r_rx_tcnt;
    w_rx_idx_nx   = r_rx_idx;
    w_rx_shift_en = 1'b0;
    w_rx_par_en   = 1'b0;
    w_rx_done     = 1'b0;
    if (w_os_tick) w_rx_tcnt_nx = w_rx_bit_mid ? '0 : r_rx_tcnt + 1'b1;
    unique case (r_rx_state)
      RX_IDLE: begin
        w_rx_tcnt_nx = '0;
        if (rxen_i && r_rx_armed && w_rx_fall) w_rx_state_nx = RX_START;
      end
      // Half a bit after the edge: still low means a real start bit.
      RX_START: if (w_os_tick && r_rx_tcnt == KW'(OVERSAMPLE / 2 - 1)) begin
        w_rx_tcnt_nx  = '0;
        w_rx_idx_nx   = '0;
        w_rx_state_nx = r_rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (w_rx_bit_mid) begin
        w_rx_shift_en = 1'b1;
        if (r_rx_idx == IW'(DATA_BITS - 1)) begin
          w_rx_idx_nx   = '0;
          w_rx_state_nx = (PARITY != 0) ? RX_PAR : RX_STOP;
        end else begin
          w_rx_idx_nx = r_rx_idx + 1'b1;
        end
      end
      RX_PAR: if (w_rx_bit_mid) begin
        w_rx_par_en   = 1'b1;
        w_rx_state_nx = RX_STOP;
      end
      RX_STOP: if (w_rx_bit_mid) begin
        w_rx_done     = 1'b1;
        w_rx_state_nx = RX_IDLE;
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_armed <= 1'b1;
      r_os_cnt   <= '0;
      r_rx_tcnt  <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
      r_rxdata   <= '0;
      r_rxvalid  <= 1'b0;
      r_rxperr   <= 1'b0;
      r_rxferr   <= 1'b0;
    end else begin
      r_rx_s1   <= rx_i;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      r_os_cnt  <= w_os_tick ? '0 : r_os_cnt + 1'b1;
      r_rx_tcnt <= w_rx_tcnt_nx;
      r_rx_idx  <= w_rx_idx_nx;
      if (w_rx_shift_en) r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
      if (w_rx_par_en)   r_rx_par   <= r_rx_s2;
      r_rxvalid <= w_rx_done;
      if (w_rx_done) begin
        r_rxdata <= r_rx_shift;
        r_rxperr <= w_rx_perr;
        r_rxferr <= ~r_rx_s2;
      end
      // A break (line held low through stop) must release high before re-arming.
      if (w_rx_done && !r_rx_s2)                  r_rx_armed <= 1'b0;
      else if (r_rx_state == RX_IDLE && r_rx_s2)  r_rx_armed <= 1'b1;
    end
  end

  assign rxdata_o  = r_rxdata;
  assign rxvalid_o = r_rxvalid;
  assign rxperr_o  = r_rxperr;
  assign rxferr_o  = r_rxferr;

endmodule
